// File: rtl/detector2_core.sv
// detector2_core
//   Frame-based "11" pattern detector. Each 10-cycle frame loads an 8-bit word,
//   scans it serially MSB first, and counts "11" pairs two ways:
//     ovl_cnt - overlapping matches (every adjacent 1-1 pair)
//     non_cnt - non-overlapping matches (a matched pair consumes both bits)
//   At the end of the frame, both counts go to the LEDs and non_cnt goes to a
//   7-segment digit. The outputs hold until the next frame completes.
//
// Parameters
//   SEG_ACTIVE_LOW : 1 = common-anode (active-low) segments, 0 = active-high.
//
// Ports
//   clk   in   1  system clock, rising edge
//   rst_n in   1  asynchronous active-low reset
//   din   in   8  word to scan, sampled once per frame in LOAD
//   led   out  8  {ovl_cnt[3:0], non_cnt[3:0]}, registered
//   seg   out  8  {dp,g,f,e,d,c,b,a} code of non_cnt, registered
module detector2_core #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    output logic [7:0] led,
    output logic [7:0] seg
);

    localparam logic [7:0] SEG_RESET = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [7:0] sr;
    logic [2:0] idx;
    logic       prev;
    logic       arm;
    logic [3:0] ovl_cnt;
    logic [3:0] non_cnt;
    logic       cur;

    // Active-low code for one decimal digit; anything above 9 blanks the digit.
    function automatic logic [7:0] seg_encode(input logic [3:0] v);
        logic [7:0] code;
        case (v)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    assign cur = sr[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    next_state = SCAN;
            SCAN:    next_state = (idx == 3'd7) ? DONE : SCAN;
            DONE:    next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            idx     <= '0;
            prev    <= 1'b0;
            arm     <= 1'b0;
            ovl_cnt <= '0;
            non_cnt <= '0;
            led     <= '0;
            seg     <= SEG_RESET;
        end else begin
            case (state)
                LOAD: begin
                    sr      <= din;
                    idx     <= '0;
                    prev    <= 1'b0;
                    arm     <= 1'b0;
                    ovl_cnt <= '0;
                    non_cnt <= '0;
                end
                SCAN: begin
                    sr      <= {sr[6:0], 1'b0};
                    idx     <= idx + 3'd1;
                    ovl_cnt <= ovl_cnt + {3'b000, prev & cur};
                    prev    <= cur;
                    // A completed pair disarms, so its second bit cannot start
                    // another non-overlapping match.
                    if (arm && cur) begin
                        non_cnt <= non_cnt + 4'd1;
                        arm     <= 1'b0;
                    end else begin
                        arm     <= cur;
                    end
                end
                DONE: begin
                    led <= {ovl_cnt, non_cnt};
                    seg <= SEG_ACTIVE_LOW ? seg_encode(non_cnt) : ~seg_encode(non_cnt);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detector2_core.sv
// tb_detector2_core
//   Drives framed words into detector2_core and compares led/seg against a
//   word-level reference: overlapping count = number of adjacent 1-1 pairs,
//   non-overlapping count = greedy left-to-right pairing.
module tb_detector2_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] led;
    logic [7:0] seg;

    int unsigned checks;
    int unsigned failures;

    logic [7:0] exp_led;
    logic [7:0] exp_seg;

    detector2_core #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .led   (led),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, want);
        end
    endtask

    function automatic int ref_ovl(input logic [7:0] w);
        int n = 0;
        for (int i = 7; i > 0; i--)
            if (w[i] && w[i-1]) n++;
        return n;
    endfunction

    function automatic int ref_non(input logic [7:0] w);
        int n = 0;
        int i = 7;
        while (i > 0) begin
            if (w[i] && w[i-1]) begin
                n++;
                i -= 2;
            end else begin
                i -= 1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] ref_seg(input int v);
        logic [7:0] lut [0:9];
        lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (v > 9) return 8'hFF;
        return lut[v];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle-point after an edge, with the next edge being LOAD.
    // Optionally changes din after the given number of SCAN cycles.
    task automatic frame(input logic [7:0] w, input bit mid_en, input int mid_at,
                         input logic [7:0] mid_w);
        int n_ovl;
        int n_non;
        din = w;
        tick();                                   // LOAD
        check("hold_led_load", led, exp_led);
        check("hold_seg_load", seg, exp_seg);
        for (int k = 0; k < 8; k++) begin
            if (mid_en && k == mid_at) din = mid_w;
            tick();                               // SCAN
        end
        check("hold_led_scan", led, exp_led);
        check("hold_seg_scan", seg, exp_seg);
        tick();                                   // DONE
        n_ovl   = ref_ovl(w);
        n_non   = ref_non(w);
        exp_led = {n_ovl[3:0], n_non[3:0]};
        exp_seg = ref_seg(n_non);
        check("frame_led", led, exp_led);
        check("frame_seg", seg, exp_seg);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_led  = 8'h00;
        exp_seg  = 8'hFF;
        rst_n    = 1'b0;
        din      = 8'h00;

        repeat (3) tick();
        check("reset_led", led, 8'h00);
        check("reset_seg", seg, 8'hFF);
        rst_n = 1'b1;

        // Directed frames
        frame(8'b11001110, 1'b0, 0, 8'h00);
        check("spec_11001110_led", led, 8'h32);
        check("spec_11001110_seg", seg, 8'hA4);
        frame(8'b11001110, 1'b0, 0, 8'h00);
        check("spec_stable_led", led, 8'h32);
        frame(8'hFF, 1'b0, 0, 8'h00);
        check("spec_ff_led", led, 8'h74);
        check("spec_ff_seg", seg, 8'h99);
        frame(8'h00, 1'b0, 0, 8'h00);
        frame(8'b10101010, 1'b0, 0, 8'h00);
        check("spec_aa_led", led, 8'h00);
        check("spec_aa_seg", seg, 8'hC0);
        frame(8'hFF, 1'b1, 3, 8'h00);
        check("spec_mid_change_led", led, 8'h74);
        frame(8'h00, 1'b0, 0, 8'h00);
        check("spec_next_frame_led", led, 8'h00);
        frame(8'b01100110, 1'b0, 0, 8'h00);
        check("spec_66_led", led, 8'h22);
        check("spec_66_seg", seg, 8'hA4);
        frame(8'b11100000, 1'b0, 0, 8'h00);
        check("spec_e0_led", led, 8'h21);
        check("spec_e0_seg", seg, 8'hF9);

        // Reset pulse in the middle of a SCAN
        din = 8'hFF;
        tick();                                   // LOAD
        repeat (4) tick();                        // partway through SCAN
        rst_n = 1'b0;
        #1;
        check("midreset_led", led, 8'h00);
        check("midreset_seg", seg, 8'hFF);
        exp_led = 8'h00;
        exp_seg = 8'hFF;
        repeat (2) tick();
        rst_n = 1'b1;
        frame(8'b11011011, 1'b0, 0, 8'h00);

        // Randomized frames with random mid-frame din disturbances
        for (int r = 0; r < 40; r++) begin
            logic [7:0] w;
            logic [7:0] m;
            w = 8'($urandom);
            m = 8'($urandom);
            frame(w, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)), m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
